rsa_modexp_engine: RTL and testbench

//  Parametrised successor to the single-exponent RSA top: one shared, constant-time modular

---
 rtl/rsa_modexp_engine.sv | 190 +++++++++++++++++++
 tb/tb_rsa_modexp_engine.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rsa_modexp_engine.sv
// Constant-time modular exponentiation engine (msg^k mod n) shared by encrypt and decrypt.
// Right-to-left square-and-multiply built on a bit-serial interleaved shift-add modular multiplier.
module rsa_modexp_engine #(
  parameter int WIDTH_N     = 8,
  parameter int WIDTH_DEG   = 8,
  parameter int WIDTH_MSG_I = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   eORd,
  input  logic [WIDTH_MSG_I-1:0] msg_i,
  input  logic [WIDTH_DEG-1:0]   e_i,
  input  logic [WIDTH_DEG-1:0]   d_i,
  input  logic [WIDTH_N-1:0]     n_i,
  output logic                   ready_o,
  output logic                   busy,
  output logic [WIDTH_N-1:0]     msg_o,
  output logic                   finish,
  output logic                   err_o
);

  localparam int CW = (WIDTH_N   > 1) ? $clog2(WIDTH_N)   : 1;
  localparam int IW = (WIDTH_DEG > 1) ? $clog2(WIDTH_DEG) : 1;
  localparam int AW = WIDTH_N + 2;

  if (WIDTH_MSG_I > WIDTH_N) begin : g_width_chk
    $error("WIDTH_MSG_I must not exceed WIDTH_N");
  end

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_MUL, S_SQR, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH_N-1:0]   n_q, n_d;
  logic [WIDTH_DEG-1:0] k_q, k_d;
  logic [WIDTH_N-1:0]   a_q, a_d;
  logic [WIDTH_N-1:0]   b_q, b_d;
  logic [WIDTH_N-1:0]   acc_q, acc_d;
  logic [WIDTH_N-1:0]   base_q, base_d;
  logic [WIDTH_N-1:0]   res_q, res_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 errf_q, errf_d;
  logic [WIDTH_N-1:0]   msg_q, msg_d;
  logic                 err_q, err_d;
  logic                 finish_q, finish_d;

  // One modmul step: acc < n is kept invariant, so a >= n (REDUCE) still works.
  logic [AW-1:0]      nx, acc_sh, acc_r1, acc_add;
  logic [WIDTH_N-1:0] mm_n;
  logic               accept, last_bit, last_idx;

  always_comb begin
    nx      = AW'(n_q);
    acc_sh  = {1'b0, acc_q, 1'b0};
    acc_r1  = (acc_sh >= nx) ? (acc_sh - nx) : acc_sh;
    acc_add = acc_r1 + (a_q[WIDTH_N-1] ? AW'(b_q) : '0);
    mm_n    = (acc_add >= nx) ? WIDTH_N'(acc_add - nx) : WIDTH_N'(acc_add);
  end

  assign ready_o  = (state_q == S_IDLE) && !finish_q;
  assign busy     = (state_q != S_IDLE) || finish_q;
  assign msg_o    = msg_q;
  assign finish   = finish_q;
  assign err_o    = err_q;
  assign accept   = start_i && ready_o;
  assign last_bit = (cnt_q == CW'(WIDTH_N - 1));
  assign last_idx = (idx_q == IW'(WIDTH_DEG - 1));

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    base_d   = base_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    errf_d   = errf_q;
    msg_d    = msg_q;
    err_d    = err_q;
    finish_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          n_d    = n_i;
          k_d    = eORd ? e_i : d_i;
          acc_d  = '0;
          cnt_d  = '0;
          idx_d  = '0;
          base_d = '0;
          res_d  = '0;
          a_d    = WIDTH_N'(msg_i);
          b_d    = WIDTH_N'(1);
          if (n_i == '0) begin
            errf_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            errf_d  = 1'b0;
            state_d = S_REDUCE;
          end
        end
      end

      S_REDUCE, S_MUL, S_SQR: begin
        acc_d = mm_n;
        a_d   = a_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          acc_d = '0;
          cnt_d = '0;
          case (state_q)
            S_REDUCE: begin
              base_d  = mm_n;
              res_d   = (n_q == WIDTH_N'(1)) ? '0 : WIDTH_N'(1);
              a_d     = (n_q == WIDTH_N'(1)) ? '0 : WIDTH_N'(1);
              b_d     = mm_n;
              state_d = S_MUL;
            end
            S_MUL: begin
              // Product is always computed; only the commit depends on the key bit.
              if (k_q[idx_q]) res_d = mm_n;
              a_d     = base_q;
              b_d     = base_q;
              state_d = S_SQR;
            end
            default: begin
              base_d = mm_n;
              a_d    = res_q;
              b_d    = mm_n;
              if (last_idx) begin
                state_d = S_DONE;
              end else begin
                idx_d   = idx_q + IW'(1);
                state_d = S_MUL;
              end
            end
          endcase
        end
      end

      S_DONE: begin
        msg_d    = res_q;
        err_d    = errf_q;
        finish_d = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      errf_q   <= 1'b0;
      msg_q    <= '0;
      err_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      k_q      <= k_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      errf_q   <= errf_d;
      msg_q    <= msg_d;
      err_q    <= err_d;
      finish_q <= finish_d;
    end
  end

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Scoreboard bench for rsa_modexp_engine: driver queues expected results, monitor checks on finish.
module tb_rsa_modexp_engine;

  logic       clk, reset, start_i, eORd;
  logic [7:0] msg_i, e_i, d_i, n_i;
  logic       ready_o, busy, finish, err_o;
  logic [7:0] msg_o;

  rsa_modexp_engine #(.WIDTH_N(8), .WIDTH_DEG(8), .WIDTH_MSG_I(8)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .eORd(eORd),
    .msg_i(msg_i), .e_i(e_i), .d_i(d_i), .n_i(n_i),
    .ready_o(ready_o), .busy(busy), .msg_o(msg_o), .finish(finish), .err_o(err_o)
  );

  typedef struct {
    int msg;
    int err;
    int lat;
    int acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pcyc  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every finish pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (finish === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_finish", 1, 0);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("msg_o", int'(msg_o), x.msg);
        chk("err_o", int'(err_o), x.err);
        chk("latency", pcyc - x.acc, x.lat);
        chk("ready_low_at_finish", int'(ready_o), 0);
        chk("busy_at_finish", int'(busy), 1);
      end
    end
  end

  task automatic issue(input logic [7:0] m, input logic [7:0] e, input logic [7:0] d,
                       input logic [7:0] n, input logic enc, input int exp_msg,
                       input int exp_err, input int exp_lat, input bit push);
    bit got;
    exp_t x;
    got = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("ready_timeout", 0, 1);
    end else begin
      msg_i = m; e_i = e; d_i = d; n_i = n; eORd = enc; start_i = 1'b1;
      x.msg = exp_msg; x.err = exp_err; x.lat = exp_lat; x.acc = pcyc;
      if (push) q.push_back(x);
      @(negedge clk);
      start_i = 1'b0;
      chk("busy_after_accept", int'(busy), 1);
      chk("ready_after_accept", int'(ready_o), 0);
    end
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; eORd = 1'b0;
    msg_i = '0; e_i = '0; d_i = '0; n_i = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_msg", int'(msg_o), 0);

    // 4^3 mod 33 = 31, then 31^7 mod 33 = 4 back-to-back
    issue(8'd4,  8'd3, 8'd0, 8'd33, 1'b1, 31, 0, 138, 1);
    issue(8'd31, 8'd0, 8'd7, 8'd33, 1'b0, 4,  0, 138, 1);

    // start pulse with new operands mid-operation must be ignored
    issue(8'd4, 8'd3, 8'd0, 8'd33, 1'b1, 31, 0, 138, 1);
    repeat (20) @(negedge clk);
    msg_i = 8'd9; n_i = 8'd35; e_i = 8'd5; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;

    issue(8'd37, 8'd1, 8'd0, 8'd33, 1'b1, 4, 0, 138, 1);
    issue(8'd5,  8'd0, 8'd0, 8'd33, 1'b1, 1, 0, 138, 1);
    issue(8'd7,  8'd5, 8'd0, 8'd1,  1'b1, 0, 0, 138, 1);
    issue(8'd9,  8'd3, 8'd0, 8'd0,  1'b1, 0, 1, 2,   1);
    issue(8'd4,  8'd3, 8'd0, 8'd33, 1'b1, 31, 0, 138, 1);

    // Abort around cycle 50; the aborted op must never produce a finish
    issue(8'd5, 8'd3, 8'd0, 8'd33, 1'b1, 0, 0, 0, 0);
    repeat (48) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_msg", int'(msg_o), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_finish", int'(finish), 0);
    chk("abort_ready", int'(ready_o), 1);
    reset = 1'b0;
    issue(8'd31, 8'd0, 8'd7, 8'd33, 1'b0, 4, 0, 138, 1);

    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drained", q.size(), 0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
